// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and the request legality check.
package dmem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // funct3[1:0] encodes the access size for every legal load/store
  function automatic logic access_err(input logic        we,
                                      input logic [2:0]  funct3,
                                      input logic [31:0] addr,
                                      input int unsigned depth_words);
    logic bad_f3;
    logic misaligned;
    logic out_of_range;
    bad_f3       = we ? (funct3 > 3'd2) : (funct3 == 3'd3 || funct3 >= 3'd6);
    misaligned   = (funct3[1:0] == 2'd1 && addr[0]) ||
                   (funct3[1:0] == 2'd2 && addr[1:0] != 2'd0);
    out_of_range = {2'b00, addr[31:2]} >= depth_words;
    return bad_f3 || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/dmem_responder_load_ext.sv
// Load lane select and sign/zero extension from a full memory word;
// shared with the pipeline writeback stage.
module dmem_load_ext
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = 8'(word >> {addr_lo, 3'b000});
    lane_half = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   data = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   data = {{16{lane_half[15]}}, lane_half};
      F3_LW:   data = word;
      F3_LBU:  data = {24'd0, lane_byte};
      F3_LHU:  data = {16'd0, lane_half};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data RAM behind a valid/ready request port: one request at a
// time, WAIT_CYCLES wait states, then a single-cycle response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            lat_we;
  logic [2:0]      lat_funct3;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;

  logic            cur_we;
  logic [2:0]      cur_funct3;
  logic [31:0]     cur_addr;
  logic [31:0]     cur_wdata;
  logic            cur_err;
  logic            enter_resp;
  logic            commit;
  logic [AW-1:0]   idx;
  logic [3:0]      be;
  logic [31:0]     wlanes;
  logic [31:0]     rd_word;
  logic [31:0]     ld_data;
  logic [31:0]     rsp_next;

  logic [31:0]     mem [DEPTH_WORDS];

  // With zero wait states the live request is executed on its acceptance edge
  always_comb begin
    if (state == IDLE) begin
      cur_we     = req_we;
      cur_funct3 = req_funct3;
      cur_addr   = req_addr;
      cur_wdata  = req_wdata;
    end else begin
      cur_we     = lat_we;
      cur_funct3 = lat_funct3;
      cur_addr   = lat_addr;
      cur_wdata  = lat_wdata;
    end
  end

  assign cur_err    = access_err(cur_we, cur_funct3, cur_addr, DEPTH_WORDS);
  assign enter_resp = (state == IDLE && req_valid && WAIT_CYCLES == 0) ||
                      (state == WAIT && cnt == '0);
  assign commit     = enter_resp && !reset && cur_we && !cur_err;
  assign idx        = cur_addr[AW+1:2];
  assign rd_word    = mem[idx];
  assign rsp_next   = (cur_err || cur_we) ? 32'd0 : ld_data;

  always_comb begin
    case (cur_funct3[1:0])
      2'd0: begin
        be     = 4'b0001 << cur_addr[1:0];
        wlanes = {4{cur_wdata[7:0]}};
      end
      2'd1: begin
        be     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{cur_wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = cur_wdata;
      end
    endcase
  end

  dmem_load_ext u_load_ext (
    .word    (rd_word),
    .addr_lo (cur_addr[1:0]),
    .funct3  (cur_funct3),
    .data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (req_valid) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            cnt        <= CNT_INIT;
            req_ready  <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rsp_next;
              rsp_err   <= cur_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_next;
            rsp_err   <= cur_err;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (2 and 0 wait states)
// checked against a byte-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          size;
    int          due;
  } exp_t;

  exp_t       expq [2][$];
  logic [7:0] mdl  [2][4*DEPTH];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         last_acc [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  function automatic int wait_of(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Expected response from the access rules, reading the byte-array model
  function automatic exp_t model(int d, logic we, logic [2:0] f3,
                                 logic [31:0] addr, logic [31:0] wdata);
    exp_t            e;
    longint unsigned v;
    int              sz;
    v  = 0;
    sz = (int'(f3) % 4 == 0) ? 1 : (int'(f3) % 4 == 1) ? 2 : 4;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.size  = sz;
    e.rdata = 32'd0;
    e.due   = 0;
    e.err   = (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) ||
              (addr % sz != 0) || (addr >= 4 * DEPTH);
    if (!we && !e.err) begin
      for (int i = 0; i < sz; i++) v = v | (longint'(mdl[d][addr + i]) << (8 * i));
      if (f3 < 3'd4 && sz < 4 && ((v >> (8 * sz - 1)) & 1) == 1)
        v = v | ~((64'd1 << (8 * sz)) - 1);
      e.rdata = v[31:0];
    end
    return e;
  endfunction

  // Leaves req_valid high on return, so consecutive calls hold the request line
  task automatic applyStimulus(int d, logic we, logic [2:0] f3,
                               logic [31:0] addr, logic [31:0] wdata);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[d] !== 1'b1) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      return;
    end
    e = model(d, we, f3, addr, wdata);
    e.due = cyc + 1 + wait_of(d);
    expq[d].push_back(e);
    last_acc[d] = cyc;
    @(posedge clk);
  endtask

  task automatic idle(int d, int n);
    @(negedge clk);
    req_valid[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkReset(int d);
    checkOutput("reset_req_ready", 32'(req_ready[d]), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata[d], 32'd0);
    checkOutput("reset_rsp_err",   32'(rsp_err[d]), 32'd0);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clk) begin : mon
      exp_t e;
      if (rst[g] !== 1'b1) begin
        if (expq[g].size() > 0 && cyc > expq[g][0].due) begin
          checkOutput("rsp_missing", 32'd0, 32'd1);
          void'(expq[g].pop_front());
        end
        if (rsp_valid[g] === 1'b1) begin
          if (expq[g].size() == 0) begin
            checkOutput("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            e = expq[g].pop_front();
            checkOutput("rsp_cycle", 32'(cyc), 32'(e.due));
            checkOutput("rsp_rdata", rsp_rdata[g], e.rdata);
            checkOutput("rsp_err", 32'(rsp_err[g]), 32'(e.err));
            if (e.we && !e.err)
              for (int i = 0; i < e.size; i++) mdl[g][e.addr + i] = 8'(e.wdata >> (8 * i));
          end
        end
      end
    end
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
      req_funct3[d] = 3'd0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
      last_acc[d] = 0;
    end
    repeat (3) @(negedge clk);
    checkReset(0);
    checkReset(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    for (int d = 0; d < 2; d++) begin
      $display("[TB] instance %0d: fill memory", d);
      for (int w = 0; w < DEPTH; w++) begin
        applyStimulus(d, 1'b1, 3'd2, 32'(4 * w), $urandom);
        if (w > 0) checkOutput("fill_throughput", 32'(last_acc[d] - n), 32'(wait_of(d) + 2));
        n = last_acc[d];
      end
      idle(d, 2);

      $display("[TB] instance %0d: directed sequence", d);
      applyStimulus(d, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      applyStimulus(d, 1'b0, 3'd2, 32'h10, 32'h0);
      applyStimulus(d, 1'b1, 3'd0, 32'h13, 32'h80);
      applyStimulus(d, 1'b0, 3'd0, 32'h13, 32'h0);
      applyStimulus(d, 1'b0, 3'd4, 32'h13, 32'h0);
      applyStimulus(d, 1'b0, 3'd2, 32'h10, 32'h0);
      applyStimulus(d, 1'b1, 3'd1, 32'h12, 32'h1234);
      applyStimulus(d, 1'b0, 3'd1, 32'h12, 32'h0);
      applyStimulus(d, 1'b0, 3'd1, 32'h11, 32'h0);
      applyStimulus(d, 1'b0, 3'd2, 32'h11, 32'h0);
      applyStimulus(d, 1'b1, 3'd2, 32'(4 * DEPTH), 32'h55AA55AA);
      applyStimulus(d, 1'b1, 3'd3, 32'h10, 32'h55AA55AA);
      applyStimulus(d, 1'b0, 3'd2, 32'h10, 32'h0);
      idle(d, 1);

      $display("[TB] instance %0d: held request line", d);
      for (int k = 0; k < 8; k++) begin
        applyStimulus(d, 1'b0, 3'd2, 32'(4 * $urandom_range(0, DEPTH - 1)), 32'h0);
        if (k > 0) checkOutput("hold_throughput", 32'(last_acc[d] - n), 32'(wait_of(d) + 2));
        n = last_acc[d];
      end
      idle(d, 2);

      $display("[TB] instance %0d: random traffic", d);
      for (int k = 0; k < 150; k++) begin
        logic [31:0] a;
        a = 32'($urandom_range(0, 4 * DEPTH + 8));
        if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
        applyStimulus(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        n = $urandom_range(0, 2);
        if (n > 0) idle(d, n);
      end
      idle(d, 4);
    end

    $display("[TB] reset during wait");
    applyStimulus(0, 1'b1, 3'd2, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    expq[0].delete();
    @(negedge clk);
    checkReset(0);
    rst[0] = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(0, 1'b0, 3'd2, 32'h20, 32'h0);
    idle(0, 1);

    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    n = 0;
    while ((expq[0].size() > 0 || expq[1].size() > 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (expq[0].size() > 0 || expq[1].size() > 0) checkOutput("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
